// File: rtl/traffic_pkg.sv
// traffic_pkg: shared frame geometry constants and loader state encoding
package traffic_pkg;
    localparam int FRAME_BITS  = 1024;
    localparam int FRAME_BYTES = 128;
    localparam int IDX_W       = 7;
    localparam int PIX_W       = 11;
    typedef enum logic [1:0] {FILL, DROP, PEND} loader_state_t;
endpackage

// File: rtl/img_frame_loader_if.sv
// img_frame_loader_if: byte-stream input and frame output handshakes of the image loader
interface img_frame_loader_if #(
    parameter int DATA_W     = 8,
    parameter int FRAME_BITS = 1024
);
    logic [DATA_W-1:0]     s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [FRAME_BITS-1:0] img_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  frame_err;
    logic [7:0]            frame_cnt;
    logic [10:0]           pix_count;
    modport master (
        output s_data, s_valid, s_last, out_ready,
        input  s_ready, img_data, out_valid, frame_err, frame_cnt, pix_count
    );
    modport slave (
        input  s_data, s_valid, s_last, out_ready,
        output s_ready, img_data, out_valid, frame_err, frame_cnt, pix_count
    );
endinterface

// File: rtl/popcount8.sv
// popcount8: number of set bits in a byte
module popcount8 (
    input  logic [7:0] din,
    output logic [3:0] cnt
);
    // sum the individual bits
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, din[i]};
    end
endmodule

// File: rtl/img_frame_loader.sv
// img_frame_loader: assembles 128 bytes into a held 1024-bit frame; IMG_LOADER_PIXCOUNT_EN adds a set-pixel count
module img_frame_loader
    import traffic_pkg::loader_state_t, traffic_pkg::FILL, traffic_pkg::DROP, traffic_pkg::PEND,
           traffic_pkg::IDX_W, traffic_pkg::PIX_W, traffic_pkg::FRAME_BYTES;
#(
    parameter int DATA_W     = 8,
    parameter int FRAME_BITS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    img_frame_loader_if.slave bus
);
    loader_state_t         state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRAME_BITS-1:0] fill_q, fill_d, img_q, img_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  ov_q, ov_d, s_ready_q, s_ready_d, err_q, err_d;
    logic                  take, last_byte, load;

    assign take      = bus.s_valid & s_ready_q;
    assign last_byte = idx_q == IDX_W'(FRAME_BYTES - 1);
    assign load      = state_q == PEND & (~ov_q | bus.out_ready);

    // byte assembly: bytes shift in from the bottom so byte 0 ends up in the top bits
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        err_d   = 1'b0;
        if (state_q == FILL && take) begin
            fill_d  = {fill_q[FRAME_BITS-DATA_W-1:0], bus.s_data};
            idx_d   = bus.s_last ? '0 : idx_q + IDX_W'(1);
            err_d   = bus.s_last ^ last_byte;
            state_d = last_byte ? (bus.s_last ? PEND : DROP) : FILL;
        end else if (state_q == DROP && take && bus.s_last) begin
            state_d = FILL;
            idx_d   = '0;
        end else if (load) begin
            state_d = FILL;
            idx_d   = '0;
        end
        s_ready_d = state_d != PEND;
        img_d     = load ? fill_q : img_q;
        ov_d      = load | (ov_q & ~bus.out_ready);
        cnt_d     = cnt_q + {7'd0, load};
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            fill_q    <= '0;
            img_q     <= '0;
            cnt_q     <= '0;
            ov_q      <= 1'b0;
            s_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fill_q    <= fill_d;
            img_q     <= img_d;
            cnt_q     <= cnt_d;
            ov_q      <= ov_d;
            s_ready_q <= s_ready_d;
            err_q     <= err_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.img_data  = img_q;
    assign bus.out_valid = ov_q;
    assign bus.frame_err = err_q;
    assign bus.frame_cnt = cnt_q;

`ifdef IMG_LOADER_PIXCOUNT_EN
    logic [3:0]       pc;
    logic [PIX_W-1:0] acc_q, acc_d, pix_q, pix_d;

    popcount8 u_popcount8 (.din(bus.s_data), .cnt(pc));

    // running set-pixel count: restarts on a frame's first byte, clears on a malformed frame
    always_comb begin
        acc_d = acc_q;
        if (state_q == FILL && take)
            acc_d = err_d ? '0 : (idx_q == '0 ? PIX_W'(pc) : acc_q + PIX_W'(pc));
        pix_d = load ? acc_q : pix_q;
    end

    // count registers, published alongside the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            pix_q <= '0;
        end else begin
            acc_q <= acc_d;
            pix_q <= pix_d;
        end
    end

    assign bus.pix_count = pix_q;
`else
    assign bus.pix_count = '0;
`endif
endmodule

// File: tb/tb_img_frame_loader.sv
// tb_img_frame_loader: directed frames checked every cycle against a queue-based model of the loader
module tb_img_frame_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    bit started = 1'b0;

    img_frame_loader_if bus ();

    img_frame_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic         m_ready, m_ov, m_err, dropping, have_pend;
    logic [1023:0] m_img, pend_img;
    logic [7:0]   m_cnt;
    logic [10:0]  m_pix, pend_pix;
    logic [7:0]   cur[$];

    task automatic chk(input string nm, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    task automatic model_step();
        logic take, load;
        started = 1'b1;
        if (!rst_n) begin
            m_ready = 0; m_ov = 0; m_err = 0; dropping = 0; have_pend = 0;
            m_img = '0; m_cnt = '0; m_pix = '0; cur.delete();
            return;
        end
        take = bus.s_valid && m_ready;
        load = have_pend && (!m_ov || bus.out_ready);
        m_err = 0;
        if (m_ov && bus.out_ready) m_ov = 0;
        if (load) begin
            m_img = pend_img; m_pix = pend_pix; m_ov = 1; m_cnt = m_cnt + 8'd1; have_pend = 0;
        end
        if (take) begin
            if (dropping) begin
                if (bus.s_last) dropping = 0;
            end else begin
                cur.push_back(bus.s_data);
                if (bus.s_last && cur.size() == 128) begin
                    pend_pix = 0;
                    for (int k = 0; k < 128; k++) begin
                        pend_img[1023-8*k -: 8] = cur[k];
`ifdef IMG_LOADER_PIXCOUNT_EN
                        pend_pix = pend_pix + 11'($countones(cur[k]));
`endif
                    end
                    have_pend = 1;
                    cur.delete();
                end else if (bus.s_last) begin
                    m_err = 1; cur.delete();
                end else if (cur.size() == 128) begin
                    m_err = 1; dropping = 1; cur.delete();
                end
            end
        end
        m_ready = !have_pend;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("s_ready", {1023'd0, bus.s_ready}, {1023'd0, m_ready});
            chk("out_valid", {1023'd0, bus.out_valid}, {1023'd0, m_ov});
            chk("frame_err", {1023'd0, bus.frame_err}, {1023'd0, m_err});
            chk("frame_cnt", {1016'd0, bus.frame_cnt}, {1016'd0, m_cnt});
            chk("pix_count", {1013'd0, bus.pix_count}, {1013'd0, m_pix});
            chk("img_data", bus.img_data, m_img);
        end
        if (bus.frame_err === 1'b1) err_seen++;
    end

    function automatic logic [7:0] byte_of(input int pat, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return pat == 0 ? 8'hFF : pat == 1 ? kb : pat == 2 ? 8'd255 - kb : kb ^ 8'hA5;
    endfunction

    task automatic send(input logic [7:0] d, input logic last);
        logic r;
        int n;
        n = 0;
        bus.s_data = d; bus.s_valid = 1'b1; bus.s_last = last;
        forever begin
            r = bus.s_ready;
            @(posedge clk); #1;
            if (r) break;
            n++;
            if (n > 500) begin
                checks++; failures++;
                $display("FAIL send_timeout t=%0t byte=%0h", $time, d);
                break;
            end
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
    endtask

    task automatic send_frame(input int n, input int lastpos, input int pat);
        for (int k = 0; k < n; k++) send(byte_of(pat, k), k == lastpos);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        bus.s_data = '0; bus.s_valid = 0; bus.s_last = 0; bus.out_ready = 0;
        idle(3);
        chk("reset_s_ready", {1023'd0, bus.s_ready}, 1024'd0);
        chk("reset_img", bus.img_data, 1024'd0);
        rst_n = 1'b1;
        // all-ones frame held for the consumer
        send_frame(128, 127, 0);
        idle(3);
        chk("ones_img", bus.img_data, {1024{1'b1}});
        chk("ones_valid", {1023'd0, bus.out_valid}, 1024'd1);
        chk("ones_cnt", {1016'd0, bus.frame_cnt}, 1024'd1);
`ifdef IMG_LOADER_PIXCOUNT_EN
        chk("ones_pix", {1013'd0, bus.pix_count}, 1024'd1024);
`else
        chk("ones_pix", {1013'd0, bus.pix_count}, 1024'd0);
`endif
        bus.out_ready = 1; idle(1); bus.out_ready = 0;
        // ramp frame held for 50 cycles
        send_frame(128, 127, 1);
        idle(50);
        chk("ramp_top", {1016'd0, bus.img_data[1023:1016]}, 1024'h00);
        chk("ramp_low", {1016'd0, bus.img_data[7:0]}, 1024'h7F);
        chk("ramp_valid", {1023'd0, bus.out_valid}, 1024'd1);
        // second frame waits in PEND behind the unconsumed one
        send_frame(128, 127, 2);
        idle(5);
        chk("pend_s_ready", {1023'd0, bus.s_ready}, 1024'd0);
        bus.out_ready = 1; idle(1); bus.out_ready = 0;
        chk("swap_top", {1016'd0, bus.img_data[1023:1016]}, 1024'hFF);
        chk("swap_low", {1016'd0, bus.img_data[7:0]}, 1024'h80);
        chk("swap_valid", {1023'd0, bus.out_valid}, 1024'd1);
        chk("swap_cnt", {1016'd0, bus.frame_cnt}, 1024'd3);
        bus.out_ready = 1;
        idle(2);
        chk("drained", {1023'd0, bus.out_valid}, 1024'd0);
        // short frame then a good one
        e0 = err_seen;
        send_frame(61, 60, 3);
        idle(3);
        chk("short_err", 1024'(err_seen - e0), 1024'd1);
        chk("short_cnt", {1016'd0, bus.frame_cnt}, 1024'd3);
        send_frame(128, 127, 3);
        idle(4);
        chk("after_short_cnt", {1016'd0, bus.frame_cnt}, 1024'd4);
        chk("after_short_top", {1016'd0, bus.img_data[1023:1016]}, 1024'hA5);
        // long frame then a good one
        e0 = err_seen;
        send_frame(140, 139, 1);
        idle(3);
        chk("long_err", 1024'(err_seen - e0), 1024'd1);
        chk("long_cnt", {1016'd0, bus.frame_cnt}, 1024'd4);
        send_frame(128, 127, 0);
        idle(4);
        chk("after_long_cnt", {1016'd0, bus.frame_cnt}, 1024'd5);
        // reset in the middle of a frame
        e0 = err_seen;
        send_frame(71, -1, 1);
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        chk("rst_img", bus.img_data, 1024'd0);
        chk("rst_cnt", {1016'd0, bus.frame_cnt}, 1024'd0);
        chk("rst_valid", {1023'd0, bus.out_valid}, 1024'd0);
        chk("rst_pix", {1013'd0, bus.pix_count}, 1024'd0);
        send_frame(128, 127, 1);
        idle(4);
        chk("post_rst_cnt", {1016'd0, bus.frame_cnt}, 1024'd1);
        chk("post_rst_err", 1024'(err_seen - e0), 1024'd0);
        chk("post_rst_low", {1016'd0, bus.img_data[7:0]}, 1024'h7F);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
